// File: rtl/voice_mixer.sv
// N-voice sample mixer: collects one sample per active voice, sums them, applies a master
// volume shift with saturation and presents the result to the codec path with a ready pulse.
module voice_mixer #(
   parameter int unsigned NUM_VOICES    = 4,
   parameter int unsigned SAMPLE_WIDTH  = 16,
   parameter int unsigned TIMEOUT       = 1023,
   parameter int unsigned TIMEOUT_WIDTH = 10
) (
   input  logic                                 i_clk,
   input  logic                                 i_reset,
   input  logic                                 i_generate_next_sample,
   input  logic [NUM_VOICES-1:0]                i_voice_active,
   input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   i_voice_sample,
   input  logic [NUM_VOICES-1:0]                i_voice_ready,
   input  logic [2:0]                           i_volume_shift,
   input  logic                                 i_mute,
   output logic [SAMPLE_WIDTH-1:0]              o_sample_out,
   output logic                                 o_new_sample_ready,
   output logic                                 o_clip,
   output logic                                 o_timeout_flag,
   output logic                                 o_missed_frame
);

   localparam int unsigned AccW = SAMPLE_WIDTH + 4;
   localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   typedef enum logic [1:0] {StIdle, StCollect, StSum, StOut} state_e;

   state_e                         r_state, w_state_d;
   logic [NUM_VOICES-1:0]          r_active, r_got;
   logic signed [SAMPLE_WIDTH-1:0] r_samp [NUM_VOICES];
   logic [TIMEOUT_WIDTH-1:0]       r_cnt;
   logic [IdxW-1:0]                r_idx;
   logic signed [AccW-1:0]         r_acc;
   logic [SAMPLE_WIDTH-1:0]        r_sample_out;
   logic                           r_ready, r_clip, r_timeout, r_missed;

   logic [NUM_VOICES-1:0]          w_take;
   logic                           w_complete, w_timeout_hit;
   logic signed [SAMPLE_WIDTH-1:0] w_cur;
   logic signed [AccW-1:0]         w_res, w_max, w_min;
   logic                           w_sat_hi, w_sat_lo;
   logic [SAMPLE_WIDTH-1:0]        w_out_val;
   logic                           w_out_clip;

   assign w_take        = i_voice_ready & r_active & ~r_got;
   assign w_complete    = (r_got == r_active);
   assign w_timeout_hit = (r_state == StCollect) && !w_complete &&
                          (r_cnt == TIMEOUT_WIDTH'(TIMEOUT - 1));

   // got is only ever set for active voices, so it alone qualifies the contribution
   assign w_cur = r_got[r_idx] ? r_samp[r_idx] : '0;

   assign w_max = {{5{1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
   assign w_min = {{5{1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};
   assign w_res = r_acc >>> i_volume_shift;

   always_comb begin
      w_sat_hi   = (w_res > w_max);
      w_sat_lo   = (w_res < w_min);
      w_out_clip = 1'b0;
      if (i_mute) begin
         w_out_val = '0;
      end else if (w_sat_hi) begin
         w_out_val  = w_max[SAMPLE_WIDTH-1:0];
         w_out_clip = 1'b1;
      end else if (w_sat_lo) begin
         w_out_val  = w_min[SAMPLE_WIDTH-1:0];
         w_out_clip = 1'b1;
      end else begin
         w_out_val = w_res[SAMPLE_WIDTH-1:0];
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:    if (i_generate_next_sample) w_state_d = StCollect;
         StCollect: if (w_complete || w_timeout_hit) w_state_d = StSum;
         StSum:     if (r_idx == IdxW'(NUM_VOICES - 1)) w_state_d = StOut;
         StOut:     w_state_d = StIdle;
         default:   w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= StIdle;
      else         r_state <= w_state_d;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_active     <= '0;
         r_got        <= '0;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_acc        <= '0;
         r_sample_out <= '0;
         r_ready      <= 1'b0;
         r_clip       <= 1'b0;
         r_timeout    <= 1'b0;
         r_missed     <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) r_samp[i] <= '0;
      end else begin
         r_ready <= 1'b0;
         r_clip  <= 1'b0;
         if (i_generate_next_sample && (r_state != StIdle)) r_missed <= 1'b1;
         if (w_timeout_hit) r_timeout <= 1'b1;
         unique case (r_state)
            StIdle: begin
               if (i_generate_next_sample) begin
                  r_active <= i_voice_active;
                  r_got    <= '0;
                  r_cnt    <= '0;
               end
            end
            StCollect: begin
               r_got <= r_got | w_take;
               r_cnt <= r_cnt + 1'b1;
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (w_take[i]) r_samp[i] <= i_voice_sample[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
               end
               if (w_state_d == StSum) begin
                  r_acc <= '0;
                  r_idx <= '0;
               end
            end
            StSum: begin
               r_acc <= r_acc + {{4{w_cur[SAMPLE_WIDTH-1]}}, w_cur};
               r_idx <= r_idx + 1'b1;
            end
            StOut: begin
               r_sample_out <= w_out_val;
               r_clip       <= w_out_clip;
               r_ready      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_sample_out       = r_sample_out;
   assign o_new_sample_ready = r_ready;
   assign o_clip             = r_clip;
   assign o_timeout_flag     = r_timeout;
   assign o_missed_frame     = r_missed;

endmodule
